egress_push_scheduler: RTL
==========================

# egress_push_scheduler

Upstream feeder for the egress parallel-to-serial converter bank. Takes one word-wide ready/valid stream per egress port from the output queues and serialises them onto the converter bank's single shared push bus (push, pushPort, pushData, pushInfo). Arbitration is round-robin, gated per port by the bank's `full` vector and by a per-port holdoff that covers the latency of that `full` feedback.

## Interface

**Parameters**
- `nbrOfPorts`, default 4: number of egress ports / input streams.
- `parrallelWidth`, default 512: word width; matches the converter bank.
- `infoWidth`, default 8: width of the opaque per-word info field; bit-packed `info_type` at integration.
- `fullLatency`, default 2: cycles a port stays ineligible after a grant.
- `portW` (derived): `(nbrOfPorts>1) ? $clog2(nbrOfPorts) : 1`.

**Ports**
- `clk` in, 1: single clock.
- `rst` in, 1: reset; **synchronous, active-high**.
- `inValid` in, [nbrOfPorts]: word available on port p.
- `inData` in, [nbrOfPorts][parrallelWidth]: word per port.
- `inInfo` in, [nbrOfPorts][infoWidth]: info per word, passed through untouched.
- `inEof` in, [nbrOfPorts]: word is last of frame.
- `inReady` out, [nbrOfPorts]: one-hot grant; word consumed this cycle.
- `full` in, [nbrOfPorts]: converter bank full per port.
- `push` out, 1: registered push strobe.
- `pushPort` out, portW: destination port of the push.
- `pushData` out, parrallelWidth: pushed word.
- `pushInfo` out, infoWidth: pushed info.

## Operation

**Eligibility.** Port p is eligible when all of these hold:
- `inValid[p]`
- `!full[p]`
- `holdoff[p]==0`
- lock rule satisfied (see Configuration).

**Arbitration.**
- Round-robin pointer `rrPtr` (portW bits). Search runs p = rrPtr, rrPtr+1, … modulo nbrOfPorts; the first eligible port wins.
- `inReady` is combinational and at most one-hot. It is all-zero when no port is eligible or when `rst` is high.
- On a grant to g, the next `rrPtr` is (g+1) mod nbrOfPorts. With no grant, `rrPtr` holds.

**Output register.**
- On a grant to g at cycle N, the following are registered at cycle N+1: `push`=1, `pushPort`=g, `pushData`=`inData[g]`, `pushInfo`=`inInfo[g]`.
- With no grant, `push`=0 at N+1. `pushPort`, `pushData` and `pushInfo` hold their last values.

**Holdoff.**
- One counter per port, width `$clog2(fullLatency+1)`.
- Loaded with `fullLatency` on a grant to that port; otherwise it decrements, saturating at 0.
- Consequence: port g granted at N is next grantable at N+fullLatency+1.
- With `fullLatency`=0, back-to-back grants to one port are allowed.

**Boundary conditions.**
- `full[p]` rising in the same cycle as an otherwise-eligible request: no grant to p.
- All ports eligible: strict rotation, one word per cycle total.
- `nbrOfPorts`=1: `pushPort` is tied 0 and `rrPtr` is constant 0.
- Wrap-around: pointer at nbrOfPorts-1 after a grant goes to 0.

**Reset.** While `rst` is high:
- `push`=0, `pushPort`=0, `pushData`=0, `pushInfo`=0.
- `inReady`=0.
- `rrPtr`=0, all holdoff counters=0, lock cleared.
- Reset asserted mid-frame discards lock state; no push is emitted in the cycle after reset deasserts unless a grant occurred in that first cycle.

## Timing

- Accept-to-push latency: exactly 1 cycle.
- Throughput: 1 word/cycle aggregate; per port, 1 word per fullLatency+1 cycles.
- `inReady` depends combinationally on `inValid`, `full` and registered state only. There is no combinational path from any input to `push`/`pushPort`/`pushData`/`pushInfo`.

## Configuration

- Macro `EGRESS_PUSH_SCHED_FRAME_LOCK_EN`.
- **Defined (frame lock):**
  - A grant of a word with `inEof`=0 locks the arbiter to that port.
  - While locked, only the locked port may be granted, and it still obeys `full` and holdoff; other ports wait even if the locked port stalls.
  - The lock is released on the cycle the locked port's `inEof`=1 word is granted; `rrPtr` then advances past that port.
- **Undefined (word interleave):** no lock state. Arbitration is per word, and frames of different ports interleave freely on the push bus.

## Test plan

- **Reset values:** hold `rst` 3 cycles with all `inValid`=1 -> `inReady`=0, `push`=0, `pushPort`=0, `pushData`=0 throughout; first grant after release is port 0.
- **Rotation and wrap:** nbrOfPorts=4, fullLatency=2, all `inValid`=1, `full`=0 -> grants 0,1,2,3,0,… one per cycle; each `push` follows its grant by 1 cycle with matching `pushPort`/`pushData`.
- **Holdoff:** only port 2 valid, fullLatency=2 -> grants at cycles N, N+3, N+6; `push`=1 at N+1, N+4, N+7 only.
- **Full gating:** ports 1 and 3 valid, `full[1]`=1 -> only port 3 is granted (at holdoff spacing); deassert `full[1]` -> port 1 is granted on the next eligible cycle per pointer.
- **Frame lock (macro defined):** port 0 sends a 3-word frame, port 1 always valid -> port 0 words granted at N, N+3, N+6 with no port-1 grant in between; port 1 granted at N+7. With the macro undefined -> port 1 is granted in the gaps.
- **Reset mid-operation:** assert `rst` for 1 cycle during a locked frame -> `push`=0 the next cycle, lock cleared, `rrPtr`=0.

Source files
------------

// File: rtl/egress_push_scheduler.sv
// Round-robin push scheduler feeding the egress converter bank's shared push bus.
// Optional frame lock: define EGRESS_PUSH_SCHED_FRAME_LOCK_EN.
module egress_push_scheduler #(
  parameter int unsigned nbrOfPorts     = 4,
  parameter int unsigned parrallelWidth = 512,
  parameter int unsigned infoWidth      = 8,
  parameter int unsigned fullLatency    = 2,
  localparam int unsigned portW         = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [nbrOfPorts-1:0]                        inValid,
  input  logic [nbrOfPorts-1:0][parrallelWidth-1:0]    inData,
  input  logic [nbrOfPorts-1:0][infoWidth-1:0]         inInfo,
  input  logic [nbrOfPorts-1:0]                        inEof,
  output logic [nbrOfPorts-1:0]                        inReady,
  input  logic [nbrOfPorts-1:0]                        full,
  output logic                                         push,
  output logic [portW-1:0]                             pushPort,
  output logic [parrallelWidth-1:0]                    pushData,
  output logic [infoWidth-1:0]                         pushInfo
);

  localparam int unsigned HoldW = (fullLatency > 0) ? $clog2(fullLatency + 1) : 1;

  logic [portW-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [nbrOfPorts-1:0][HoldW-1:0]   holdoff_q;
  logic [nbrOfPorts-1:0]              lock_ok;
  logic [nbrOfPorts-1:0]              eligible;
  logic                               grant_valid;
  logic [portW-1:0]                   grant_port;
  logic                               push_q;
  logic [portW-1:0]                   push_port_q;
  logic [parrallelWidth-1:0]          push_data_q;
  logic [infoWidth-1:0]               push_info_q;

`ifdef EGRESS_PUSH_SCHED_FRAME_LOCK_EN
  logic             lock_q;
  logic [portW-1:0] lock_port_q;

  always_comb begin
    lock_ok = '0;
    for (int p = 0; p < int'(nbrOfPorts); p++) begin
      lock_ok[p] = !lock_q || (portW'(p) == lock_port_q);
    end
  end

  // A non-final word locks the bus to its port; the final word releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= 1'b0;
      lock_port_q <= '0;
    end else if (grant_valid) begin
      lock_q      <= !inEof[grant_port];
      lock_port_q <= grant_port;
    end
  end
`else
  logic unused_eof;
  assign unused_eof = ^inEof;
  assign lock_ok    = '1;
`endif

  always_comb begin
    eligible = '0;
    for (int p = 0; p < int'(nbrOfPorts); p++) begin
      eligible[p] = inValid[p] && !full[p] && (holdoff_q[p] == '0) && lock_ok[p];
    end
  end

  // First eligible port at or after the pointer, modulo nbrOfPorts.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    for (int i = 0; i < int'(nbrOfPorts); i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % int'(nbrOfPorts);
      if (!grant_valid && eligible[portW'(idx)]) begin
        grant_valid = 1'b1;
        grant_port  = portW'(idx);
      end
    end
    if (rst) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    inReady = '0;
    if (grant_valid) begin
      inReady[grant_port] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = portW'((32'(grant_port) + 32'd1) % nbrOfPorts);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      holdoff_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int p = 0; p < int'(nbrOfPorts); p++) begin
        if (grant_valid && (grant_port == portW'(p))) begin
          holdoff_q[p] <= HoldW'(fullLatency);
        end else if (holdoff_q[p] != '0) begin
          holdoff_q[p] <= holdoff_q[p] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q      <= 1'b0;
      push_port_q <= '0;
      push_data_q <= '0;
      push_info_q <= '0;
    end else begin
      push_q <= grant_valid;
      if (grant_valid) begin
        push_port_q <= grant_port;
        push_data_q <= inData[grant_port];
        push_info_q <= inInfo[grant_port];
      end
    end
  end

  assign push     = push_q;
  assign pushPort = push_port_q;
  assign pushData = push_data_q;
  assign pushInfo = push_info_q;

endmodule
